pet_io_bridge: RTL and testbench
================================

// Module: pet_io_bridge
//
// PURPOSE
//   Parametrised I/O bridge and interrupt controller for the PET I/O window.
//   Decodes CPU I/O accesses onto NCHAN peripheral channels (PIA/VIA-class devices)
//     using per-channel base/mask matching.
//   Runs a request/ack handshake with a timeout on each access.
//   Registers the read data and aggregates channel IRQs through mask, pending and
//     edge/level mode registers. Sits between the CPU bus and the peripheral chips.
//
// PARAMETERS
//   NCHAN        4          number of peripheral channels (1..8)
//   ADDR_W       11         CPU I/O address width
//   DATA_W       8          data width (must be 8)
//   CHAN_BASE    {11'h040,11'h020,11'h010,11'h008}   packed NCHAN*ADDR_W; ch i = bits [i*ADDR_W +: ADDR_W]
//   CHAN_MASK    {11'h7F0,11'h7FC,11'h7FC,11'h7FC}   packed NCHAN*ADDR_W decode masks
//   CTRL_BASE    11'h7F0    base of bridge control block (4 regs, mask 11'h7FC)
//   TIMEOUT      15         max WAIT cycles before an access is abandoned (1..255)
//   UNMAPPED_VAL 8'hFF      read data for unmapped or timed-out accesses
//
// PORTS
//   clk         in   1               system clock, all logic on rising edge
//   reset_n     in   1               asynchronous, active-low reset
//   cpu_req     in   1               one-cycle access request (rdy-qualified)
//   cpu_we      in   1               1 = write, sampled with cpu_req
//   cpu_addr    in   ADDR_W          access address, sampled with cpu_req
//   cpu_din     in   DATA_W          write data, sampled with cpu_req
//   cpu_dout    out  DATA_W          registered read data, valid while cpu_ack=1
//   cpu_ack     out  1               one-cycle completion pulse
//   ch_strobe   out  NCHAN           one-hot access strobe, high for exactly one cycle
//   ch_we       out  1               write qualifier, held from strobe until ack/timeout
//   ch_addr     out  4               cpu_addr[3:0], held from strobe until ack/timeout
//   ch_wdata    out  DATA_W          write data, held from strobe until ack/timeout
//   ch_rdata    in   NCHAN*DATA_W    per-channel read data, sampled when ch_ack is seen
//   ch_ack      in   NCHAN           per-channel completion; may be high in the strobe cycle
//   ch_irq      in   NCHAN           per-channel interrupt request (synchronous to clk)
//   irq         out  1               registered CPU interrupt, active high
//
// BEHAVIOUR
//   Reset: all outputs 0, FSM=IDLE, mask/edge/pending/status regs 0, timeout counter 0.
//   Decode:
//     - Ch i hits when (cpu_addr & CHAN_MASK[i]) == CHAN_BASE[i]; lowest i wins.
//     - CTRL hits when (cpu_addr & 11'h7FC) == CTRL_BASE. CTRL has priority over channels.
//   FSM IDLE/STROBE/WAIT/DONE:
//     - IDLE: cpu_req with a channel hit -> latch we/addr/wdata and the channel -> STROBE.
//     - IDLE: CTRL hit or unmapped -> DONE directly. Latency req->ack = 1 cycle.
//     - STROBE: ch_strobe[sel]=1 for this cycle only. If ch_ack[sel]=1 -> DONE, else -> WAIT.
//     - WAIT: count++ each cycle. ch_ack[sel] -> DONE. count==TIMEOUT -> DONE with timeout.
//     - DONE: cpu_ack=1 for one cycle -> IDLE.
//     - Minimum channel latency: req at edge T, strobe in T+1, cpu_ack in T+2.
//     - cpu_dout is loaded on the edge entering DONE:
//         ch_rdata[sel] for a read ack, UNMAPPED_VAL for unmapped/timeout, reg value for CTRL.
//         Writes leave cpu_dout unchanged.
//     - Only ch_ack[sel] is honoured; acks from other channels are ignored.
//     - cpu_req outside IDLE is dropped and sets status[1] (overrun).
//   CTRL regs (offset = addr[1:0]):
//     - 0 MASK R/W.
//     - 1 PEND: read; write-1-clears edge-mode bits only.
//     - 2 EDGE R/W (1 = rising-edge mode).
//     - 3 STATUS: bit0 timeout, bit1 overrun; sticky; write-1-clears.
//     - Bits >= NCHAN read 0.
//   PEND[i]:
//     - Level mode: = ch_irq[i] registered.
//     - Edge mode: set on ch_irq[i] 0->1 (one prev-sample register); cleared by W1C.
//       Set wins over a same-cycle clear.
//     - Switching EDGE bit i clears PEND[i] on that write.
//   irq = registered |(PEND & MASK); 1 cycle after the PEND update.
//   Status set and W1C in the same cycle: set wins.
//   Reset mid-access: FSM returns to IDLE immediately. No strobe/ack glitch, no pending
//     access is replayed after release.
//
// TESTING
//   - Read ch1 (addr 11'h011), ch_ack[1] in strobe cycle, ch_rdata[1]=8'h5A
//       -> ch_strobe=4'b0010 one cycle; cpu_ack 2 cycles after req; cpu_dout=8'h5A.
//   - Read ch3 with no ack
//       -> cpu_ack after 1+TIMEOUT+1 cycles; cpu_dout=8'hFF; STATUS read = 8'h01;
//          write 8'h01 to STATUS -> reads 8'h00.
//   - Read unmapped addr 11'h100 -> no ch_strobe; cpu_ack next cycle; cpu_dout=8'hFF.
//   - MASK=8'h05, EDGE=8'h01; pulse ch_irq[0] 1 cycle -> PEND=8'h01, irq=1;
//       W1C PEND 8'h01 -> irq=0. Hold ch_irq[2]=1 -> irq=1 until ch_irq[2]=0.
//   - Edge on ch_irq[0] in same cycle as W1C of PEND bit0 -> PEND bit0 stays 1.
//   - cpu_req during WAIT -> dropped, STATUS bit1=1.
//       Assert reset_n=0 during WAIT -> all outputs 0, next req served normally.

Source files
------------

// File: rtl/pet_io_bridge_if.sv
// CPU-side and peripheral-side signal bundle for the PET I/O bridge.
// The slave modport is the bridge's view; master is the CPU/peripheral side.
interface pet_io_bridge_if #(
  parameter int unsigned NCHAN  = 4,
  parameter int unsigned ADDR_W = 11,
  parameter int unsigned DATA_W = 8
);
  logic                    cpu_req;
  logic                    cpu_we;
  logic [ADDR_W-1:0]       cpu_addr;
  logic [DATA_W-1:0]       cpu_din;
  logic [DATA_W-1:0]       cpu_dout;
  logic                    cpu_ack;
  logic [NCHAN-1:0]        ch_strobe;
  logic                    ch_we;
  logic [3:0]              ch_addr;
  logic [DATA_W-1:0]       ch_wdata;
  logic [NCHAN*DATA_W-1:0] ch_rdata;
  logic [NCHAN-1:0]        ch_ack;
  logic [NCHAN-1:0]        ch_irq;
  logic                    irq;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_din, ch_rdata, ch_ack, ch_irq,
    output cpu_dout, cpu_ack, ch_strobe, ch_we, ch_addr, ch_wdata, irq
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_din, ch_rdata, ch_ack, ch_irq,
    input  cpu_dout, cpu_ack, ch_strobe, ch_we, ch_addr, ch_wdata, irq
  );
endinterface

// File: rtl/pet_io_bridge.sv
// PET I/O window bridge: decodes CPU accesses onto peripheral channels with a
// strobe/ack handshake and timeout, and aggregates channel IRQs via mask/pend/edge regs.
module pet_io_bridge #(
  parameter int unsigned               NCHAN        = 4,
  parameter int unsigned               ADDR_W       = 11,
  parameter int unsigned               DATA_W       = 8,
  parameter logic [NCHAN*ADDR_W-1:0]   CHAN_BASE    = {11'h040, 11'h020, 11'h010, 11'h008},
  parameter logic [NCHAN*ADDR_W-1:0]   CHAN_MASK    = {11'h7F0, 11'h7FC, 11'h7FC, 11'h7FC},
  parameter logic [ADDR_W-1:0]         CTRL_BASE    = 11'h7F0,
  parameter int unsigned               TIMEOUT      = 15,
  parameter logic [DATA_W-1:0]         UNMAPPED_VAL = 8'hFF
) (
  input logic           clk,
  input logic           reset_n,
  pet_io_bridge_if.slave bus
);

  localparam int unsigned       SelW     = (NCHAN > 1) ? $clog2(NCHAN) : 1;
  localparam logic [ADDR_W-1:0] CtrlMask = ~ADDR_W'(3);

  typedef enum logic [1:0] {StIdle, StStrobe, StWait, StDone} state_e;

  state_e            state_q, state_d;
  logic [SelW-1:0]   sel_q, sel_d;
  logic              we_q, we_d;
  logic [3:0]        addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic [7:0]        count_q, count_d;
  logic [NCHAN-1:0]  mask_q, mask_d, edge_q, edge_d, pend_q, pend_d, irq_prev_q;
  logic [1:0]        status_q, status_d;
  logic              irq_q;

  logic              ctrl_hit, chan_hit, ctrl_wr, timeout_set, overrun_set, ack_sel, active;
  logic [SelW-1:0]   chan_idx;
  logic [DATA_W-1:0] ctrl_rdata, rdata_sel;
  logic [NCHAN-1:0]  wr_bits, pend_clr, ch_strobe;

  // Descending scan so the lowest matching channel wins.
  always_comb begin
    ctrl_hit = (bus.cpu_addr & CtrlMask) == CTRL_BASE;
    chan_hit = 1'b0;
    chan_idx = '0;
    for (int i = NCHAN - 1; i >= 0; i--) begin
      if ((bus.cpu_addr & CHAN_MASK[i*ADDR_W +: ADDR_W]) == CHAN_BASE[i*ADDR_W +: ADDR_W]) begin
        chan_hit = 1'b1;
        chan_idx = SelW'(i);
      end
    end
  end

  assign wr_bits   = bus.cpu_din[NCHAN-1:0];
  assign ack_sel   = bus.ch_ack[sel_q];
  assign rdata_sel = bus.ch_rdata[sel_q*DATA_W +: DATA_W];

  always_comb begin
    ctrl_rdata = '0;
    case (bus.cpu_addr[1:0])
      2'd0:    ctrl_rdata[NCHAN-1:0] = mask_q;
      2'd1:    ctrl_rdata[NCHAN-1:0] = pend_q;
      2'd2:    ctrl_rdata[NCHAN-1:0] = edge_q;
      default: ctrl_rdata[1:0]       = status_q;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    dout_d      = dout_q;
    count_d     = count_q;
    ctrl_wr     = 1'b0;
    timeout_set = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.cpu_req) begin
          if (ctrl_hit) begin
            state_d = StDone;
            ctrl_wr = bus.cpu_we;
            if (!bus.cpu_we) dout_d = ctrl_rdata;
          end else if (chan_hit) begin
            state_d = StStrobe;
            sel_d   = chan_idx;
            we_d    = bus.cpu_we;
            addr_d  = bus.cpu_addr[3:0];
            wdata_d = bus.cpu_din;
          end else begin
            state_d = StDone;
            if (!bus.cpu_we) dout_d = UNMAPPED_VAL;
          end
        end
      end
      StStrobe: begin
        count_d = '0;
        if (ack_sel) begin
          state_d = StDone;
          if (!we_q) dout_d = rdata_sel;
        end else begin
          state_d = StWait;
        end
      end
      StWait: begin
        count_d = count_q + 8'd1;
        if (ack_sel) begin
          state_d = StDone;
          if (!we_q) dout_d = rdata_sel;
        end else if (count_d == 8'(TIMEOUT)) begin
          state_d     = StDone;
          timeout_set = 1'b1;
          if (!we_q) dout_d = UNMAPPED_VAL;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign overrun_set = bus.cpu_req && (state_q != StIdle);

  // Edge-mode pend bits: a new rising edge beats a same-cycle W1C; an EDGE switch clears.
  always_comb begin
    mask_d   = mask_q;
    edge_d   = edge_q;
    status_d = status_q;
    pend_clr = '0;
    if (ctrl_wr) begin
      case (bus.cpu_addr[1:0])
        2'd0:    mask_d   = wr_bits;
        2'd1:    pend_clr = wr_bits;
        2'd2:    edge_d   = wr_bits;
        default: status_d = status_q & ~bus.cpu_din[1:0];
      endcase
    end
    status_d = status_d | {overrun_set, timeout_set};
    pend_d   = pend_q;
    for (int i = 0; i < NCHAN; i++) begin
      if (edge_q[i]) begin
        pend_d[i] = (bus.ch_irq[i] & ~irq_prev_q[i]) | (pend_q[i] & ~pend_clr[i]);
      end else begin
        pend_d[i] = bus.ch_irq[i];
      end
    end
    pend_d = pend_d & ~(edge_d ^ edge_q);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      sel_q      <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      dout_q     <= '0;
      count_q    <= '0;
      mask_q     <= '0;
      edge_q     <= '0;
      pend_q     <= '0;
      irq_prev_q <= '0;
      status_q   <= '0;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      dout_q     <= dout_d;
      count_q    <= count_d;
      mask_q     <= mask_d;
      edge_q     <= edge_d;
      pend_q     <= pend_d;
      irq_prev_q <= bus.ch_irq;
      status_q   <= status_d;
      irq_q      <= |(pend_q & mask_q);
    end
  end

  always_comb begin
    ch_strobe = '0;
    if (state_q == StStrobe) ch_strobe[sel_q] = 1'b1;
  end

  assign active        = (state_q == StStrobe) || (state_q == StWait);
  assign bus.ch_strobe = ch_strobe;
  assign bus.ch_we     = active & we_q;
  assign bus.ch_addr   = active ? addr_q : 4'h0;
  assign bus.ch_wdata  = active ? wdata_q : '0;
  assign bus.cpu_ack   = (state_q == StDone);
  assign bus.cpu_dout  = dout_q;
  assign bus.irq       = irq_q;

endmodule

// File: tb/tb_pet_io_bridge.sv
// Randomised bench for pet_io_bridge: transaction-level timeline model plus an IRQ
// register model, checked every cycle, with directed cases pinned to literal values.
module tb_pet_io_bridge;
  localparam int          TIMEOUT   = 15;
  localparam logic [10:0] CTRL_BASE = 11'h7F0;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  pet_io_bridge_if #(.NCHAN(4), .ADDR_W(11), .DATA_W(8)) bus ();

  pet_io_bridge #(
    .NCHAN(4), .ADDR_W(11), .DATA_W(8),
    .CHAN_BASE({11'h040, 11'h020, 11'h010, 11'h008}),
    .CHAN_MASK({11'h7F0, 11'h7FC, 11'h7FC, 11'h7FC}),
    .CTRL_BASE(CTRL_BASE), .TIMEOUT(TIMEOUT), .UNMAPPED_VAL(8'hFF)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  logic [10:0] base_a [4] = '{11'h008, 11'h010, 11'h020, 11'h040};
  logic [10:0] mask_a [4] = '{11'h7FC, 11'h7FC, 11'h7FC, 11'h7F0};

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit irq_rand = 0;

  // Register-level model of the control block.
  logic [3:0] mask_m = 0, edge_m = 0, pend_m = 0, prev_m = 0;
  logic [1:0] status_m = 0;
  logic       irq_m = 0;
  int         wr_edge = -1, to_edge = -1, ov_edge = -1;
  logic [1:0] wr_off = 0;
  logic [7:0] wr_data = 0;

  // Timeline of the access in flight.
  int         strobe_cyc = -1, ack_cyc = -1;
  logic [3:0] exp_strobe = 0, exp_addr = 0;
  logic       exp_we = 0;
  logic [7:0] exp_wdata = 0, dout_old = 0, dout_new = 0;

  int         seen_ack = -1, last_req = 0;
  logic [3:0] seen_strobe = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 30)
        $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] ctrl_rd(input logic [1:0] off);
    case (off)
      2'd0:    return {4'h0, mask_m};
      2'd1:    return {4'h0, pend_m};
      2'd2:    return {4'h0, edge_m};
      default: return {6'h0, status_m};
    endcase
  endfunction

  always @(posedge clk) begin
    int         n;
    logic       nirq;
    logic [3:0] edge_next, clr;
    n = cyc + 1;
    if (reset_n) begin
      nirq      = |(pend_m & mask_m);
      clr       = (wr_edge == n && wr_off == 2'd1) ? wr_data[3:0] : 4'h0;
      edge_next = (wr_edge == n && wr_off == 2'd2) ? wr_data[3:0] : edge_m;
      for (int i = 0; i < 4; i++) begin
        if (edge_next[i] != edge_m[i]) pend_m[i] = 1'b0;
        else if (edge_m[i]) pend_m[i] = (bus.ch_irq[i] && !prev_m[i]) || (pend_m[i] && !clr[i]);
        else pend_m[i] = bus.ch_irq[i];
      end
      prev_m = bus.ch_irq;
      if (wr_edge == n && wr_off == 2'd0) mask_m = wr_data[3:0];
      if (wr_edge == n && wr_off == 2'd3) status_m = status_m & ~wr_data[1:0];
      edge_m = edge_next;
      if (to_edge == n) status_m[0] = 1'b1;
      if (ov_edge == n) status_m[1] = 1'b1;
      irq_m = nirq;
    end
    cyc = n;
  end

  always @(negedge clk) begin
    if (!reset_n) begin
      chk("reset_outputs", {bus.cpu_dout, bus.cpu_ack, bus.ch_strobe, bus.ch_we, bus.ch_addr,
                            bus.ch_wdata, bus.irq}, 32'h0);
    end else begin
      if (bus.cpu_ack) seen_ack = cyc;
      if (|bus.ch_strobe) seen_strobe = bus.ch_strobe;
      chk("cpu_ack", bus.cpu_ack, cyc == ack_cyc);
      chk("ch_strobe", bus.ch_strobe, (cyc == strobe_cyc) ? exp_strobe : 4'h0);
      if (strobe_cyc >= 0 && cyc >= strobe_cyc && cyc < ack_cyc)
        chk("ch_hold", {bus.ch_we, bus.ch_addr, bus.ch_wdata}, {exp_we, exp_addr, exp_wdata});
      chk("cpu_dout", bus.cpu_dout, (ack_cyc >= 0 && cyc >= ack_cyc) ? dout_new : dout_old);
      chk("irq", bus.irq, irq_m);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (irq_rand)
      for (int i = 0; i < 4; i++)
        if ($urandom_range(0, 5) == 0) bus.ch_irq[i] = ~bus.ch_irq[i];
  endtask

  task automatic idle(input int n);
    bus.cpu_req = 1'b0;
    repeat (n) begin
      bus.ch_ack = 4'($urandom);
      step();
    end
  endtask

  task automatic do_reset(input int n);
    reset_n = 1'b0;
    bus.cpu_req = 1'b0;
    bus.ch_ack = 4'h0;
    mask_m = 0; edge_m = 0; pend_m = 0; prev_m = 0; status_m = 0; irq_m = 0;
    wr_edge = -1; to_edge = -1; ov_edge = -1;
    strobe_cyc = -1; ack_cyc = -1; dout_old = 0; dout_new = 0;
    repeat (n) step();
    reset_n = 1'b1;
  endtask

  // dly: ack offset from the strobe cycle (> TIMEOUT means never); abort: reset offset.
  task automatic access(input logic we, input logic [10:0] addr, input logic [7:0] din,
                        input logic [7:0] rd, input int dly, input bit stray, input int abort);
    int hit, e, so;
    bit ctl;
    ctl = (addr & 11'h7FC) == CTRL_BASE;
    hit = -1;
    if (!ctl)
      for (int i = 3; i >= 0; i--)
        if ((addr & mask_a[i]) == base_a[i]) hit = i;
    e = cyc + 1;
    last_req = cyc;
    seen_ack = -1;
    seen_strobe = 4'h0;
    bus.cpu_req = 1'b1;
    bus.cpu_we = we;
    bus.cpu_addr = addr;
    bus.cpu_din = din;
    for (int i = 0; i < 4; i++) bus.ch_rdata[i*8 +: 8] = 8'($urandom);
    if (hit >= 0) bus.ch_rdata[hit*8 +: 8] = rd;
    bus.ch_ack = 4'($urandom);
    if (hit < 0) begin
      strobe_cyc = -1;
      if (ctl) begin
        if (we) begin
          wr_edge = e; wr_off = addr[1:0]; wr_data = din;
        end else begin
          dout_new = ctrl_rd(addr[1:0]);
        end
      end else if (!we) begin
        dout_new = 8'hFF;
      end
      ack_cyc = e;
    end else begin
      exp_strobe = 4'(1 << hit);
      exp_we = we; exp_addr = addr[3:0]; exp_wdata = din;
      if (dly <= TIMEOUT) begin
        if (!we) dout_new = rd;
        ack_cyc = e + 1 + dly;
      end else begin
        if (!we) dout_new = 8'hFF;
        ack_cyc = e + 1 + TIMEOUT;
        to_edge = ack_cyc;
      end
      strobe_cyc = e;
    end
    so = stray ? e + $urandom_range(0, ack_cyc - e) : -1;
    step();
    while (cyc <= ack_cyc) begin
      if (abort >= 0 && cyc == e + abort) begin
        do_reset(2);
        return;
      end
      bus.ch_ack = 4'($urandom);
      if (hit >= 0) bus.ch_ack[hit] = (cyc == e + dly);
      if (cyc == so) begin
        bus.cpu_req = 1'b1;
        bus.cpu_addr = 11'($urandom);
        ov_edge = cyc + 1;
      end else begin
        bus.cpu_req = 1'b0;
      end
      step();
    end
    bus.cpu_req = 1'b0;
    dout_old = dout_new;
    ack_cyc = -1;
    strobe_cyc = -1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int k;
    logic [10:0] a;
    bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = 0; bus.cpu_din = 0;
    bus.ch_rdata = 0; bus.ch_ack = 0; bus.ch_irq = 0;
    do_reset(3);
    chk("reset_dout", bus.cpu_dout, 8'h00);

    // Channel 1 read acked in the strobe cycle.
    access(1'b0, 11'h011, 8'h00, 8'h5A, 0, 1'b0, -1);
    chk("ch1_dout", bus.cpu_dout, 8'h5A);
    chk("ch1_strobe", seen_strobe, 4'b0010);
    chk("ch1_latency", seen_ack - last_req, 2);

    // Channel 3 read with no ack times out.
    access(1'b0, 11'h045, 8'h00, 8'h33, 99, 1'b0, -1);
    chk("to_dout", bus.cpu_dout, 8'hFF);
    chk("to_latency", seen_ack - last_req, 17);
    access(1'b0, 11'h7F3, 8'h00, 8'h00, 0, 1'b0, -1);
    chk("to_status", bus.cpu_dout, 8'h01);
    access(1'b1, 11'h7F3, 8'h01, 8'h00, 0, 1'b0, -1);
    access(1'b0, 11'h7F3, 8'h00, 8'h00, 0, 1'b0, -1);
    chk("to_status_clr", bus.cpu_dout, 8'h00);

    // Unmapped read.
    access(1'b0, 11'h100, 8'h00, 8'h00, 0, 1'b0, -1);
    chk("unm_dout", bus.cpu_dout, 8'hFF);
    chk("unm_strobe", seen_strobe, 4'h0);
    chk("unm_latency", seen_ack - last_req, 1);

    // IRQ: edge mode on ch0, level mode on ch2.
    access(1'b1, 11'h7F0, 8'h05, 8'h00, 0, 1'b0, -1);
    access(1'b1, 11'h7F2, 8'h01, 8'h00, 0, 1'b0, -1);
    bus.ch_irq[0] = 1'b1; step(); bus.ch_irq[0] = 1'b0; idle(3);
    access(1'b0, 11'h7F1, 8'h00, 8'h00, 0, 1'b0, -1);
    chk("pend_edge", bus.cpu_dout, 8'h01);
    chk("irq_edge", bus.irq, 1'b1);
    access(1'b1, 11'h7F1, 8'h01, 8'h00, 0, 1'b0, -1);
    idle(2);
    chk("irq_w1c", bus.irq, 1'b0);
    bus.ch_irq[2] = 1'b1; idle(3);
    chk("irq_level_hi", bus.irq, 1'b1);
    bus.ch_irq[2] = 1'b0; idle(3);
    chk("irq_level_lo", bus.irq, 1'b0);

    // Rising edge coincident with W1C of the same bit: set wins.
    bus.ch_irq[0] = 1'b1; step(); bus.ch_irq[0] = 1'b0; idle(2);
    bus.ch_irq[0] = 1'b1;
    access(1'b1, 11'h7F1, 8'h01, 8'h00, 0, 1'b0, -1);
    bus.ch_irq[0] = 1'b0;
    access(1'b0, 11'h7F1, 8'h00, 8'h00, 0, 1'b0, -1);
    chk("pend_set_wins", bus.cpu_dout, 8'h01);
    access(1'b1, 11'h7F1, 8'h01, 8'h00, 0, 1'b0, -1);

    // Overrun while a channel access is outstanding.
    access(1'b0, 11'h021, 8'h00, 8'h77, 5, 1'b1, -1);
    chk("ovr_dout", bus.cpu_dout, 8'h77);
    access(1'b0, 11'h7F3, 8'h00, 8'h00, 0, 1'b0, -1);
    chk("ovr_status", bus.cpu_dout, 8'h02);
    access(1'b1, 11'h7F3, 8'h03, 8'h00, 0, 1'b0, -1);

    // Reset during WAIT, then a normal access.
    access(1'b0, 11'h045, 8'h00, 8'h00, 99, 1'b0, 4);
    chk("abort_dout", bus.cpu_dout, 8'h00);
    access(1'b0, 11'h011, 8'h00, 8'hA5, 1, 1'b0, -1);
    chk("post_rst_dout", bus.cpu_dout, 8'hA5);
    chk("post_rst_latency", seen_ack - last_req, 3);

    // Randomised traffic.
    irq_rand = 1;
    repeat (300) begin
      case ($urandom_range(0, 3))
        0: begin
          k = $urandom_range(0, 3);
          a = base_a[k] | (11'($urandom) & ~mask_a[k]);
        end
        1: a = CTRL_BASE | 11'($urandom_range(0, 3));
        2: a = 11'($urandom);
        default: a = 11'h100;
      endcase
      access(1'($urandom), a, 8'($urandom), 8'($urandom), $urandom_range(0, TIMEOUT + 3),
             ($urandom_range(0, 7) == 0), -1);
      idle($urandom_range(0, 2));
    end
    idle(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
